hk_byte_egress: RTL and testbench
=================================

# hk_byte_egress

Housekeeper egress serializer: the transmit-side counterpart of the housekeeper byte ingress command parser. On a read request it fetches N 32-bit words from the housekeeper register bus and streams a framed response to the host link, one byte per transfer, LSB first. The response uses the same word framing as host commands: command word, length word, data words, and a terminating `ABCD` word.

## Interface
Parameters
- `LEN_W`, default 16: width of the word-count field.

Ports
- `ClkEgress`  in  1: single clock; all logic is on its rising edge.
- `ARstn`  in  1: asynchronous, active-low reset.
- `RdReq`  in  1: one-cycle pulse that starts a read response.
- `RdAddr`  in  24: start byte address; sampled with `RdReq`.
- `RdLen`  in  LEN_W: number of words to read; sampled with `RdReq`.
- `Busy`  out  1: high from `RdReq` acceptance until the last trailer byte is accepted.
- `ErrOverlap`  out  1: one-cycle pulse when `RdReq` arrives while `Busy`.
- `RegRdEn`  out  1: one-cycle register read strobe.
- `RegRdAddr`  out  24: register read address; valid with `RegRdEn`.
- `RegRdData`  in  32: read data.
- `RegRdValid`  in  1: qualifies `RegRdData`; arrives 1 or more cycles after `RegRdEn`.
- `TxData`  out  8: output byte.
- `TxValid`  out  1: `TxData` valid.
- `TxRdyn`  in  1: active-low sink ready. A byte transfers on a cycle with `TxValid && !TxRdyn`.

## Operation
- Frame words, in order:
  - `{RdAddr, 8'h82}`
  - `{(32-LEN_W)'b0, RdLen}`
  - `RdLen` data words
  - `{16'hABCD, crc}`
- Each word is sent as 4 bytes, `[7:0]` first. Frame length is `4*(RdLen+3)` bytes.
- FSM states: IDLE, HDR, LEN, RDREQ, RDWAIT, DATA, TRL.
  - IDLE: on `RdReq`, latch address and length, load the header word into the shift register, go to HDR.
  - HDR: after 4 accepted bytes, load the length word and go to LEN.
  - LEN: after 4 accepted bytes, go to RDREQ if `RdLen != 0`, otherwise go to TRL.
  - RDREQ: pulse `RegRdEn` with the current address and go to RDWAIT.
  - RDWAIT: on `RegRdValid`, load `RegRdData` into the shift register and go to DATA.
  - DATA: after 4 accepted bytes, decrement the remaining count and add 4 to the address. Go to RDREQ if the count is nonzero, otherwise to TRL.
  - TRL: after 4 accepted bytes, drop `Busy` and return to IDLE.
- Byte counter is 2 bits and wraps 3→0 at each word boundary. The remaining-word counter is LEN_W bits. The address adds 4 modulo 2^24, so `0xFFFFFC` wraps to `0x000000`.
- `RegRdValid` is ignored outside RDWAIT.
- `RdReq` while `Busy`: the request is dropped, `ErrOverlap` pulses, and the current frame is unaffected.
- `RdLen = 0`: frame is header, length, trailer (12 bytes), and no `RegRdEn` is issued.

## Timing
- Reset values (applied asynchronously on `ARstn` low): `Busy`=0, `ErrOverlap`=0, `RegRdEn`=0, `RegRdAddr`=0, `TxData`=0, `TxValid`=0. FSM goes to IDLE and all counters and CRC are cleared.
- Reset mid-frame aborts the frame. No partial resume occurs after `ARstn` rises.
- `RdReq` in cycle t gives `Busy`=1 and `TxValid`=1 with `TxData`=8'h82 in cycle t+1.
- `TxValid` stays high from HDR through TRL, except in RDREQ and RDWAIT, where it is 0.
- While `TxValid && TxRdyn`, `TxData` holds stable.
- Throughput is 1 byte/cycle with `TxRdyn` held low.
- The accept of byte 3 of LEN or DATA in cycle t gives `RegRdEn` in cycle t+1. The first data byte follows 1 cycle after `RegRdValid`.
- `Busy` falls the cycle after the last trailer byte is accepted. A new `RdReq` in that cycle is accepted.

## Configuration
- `HK_EGRESS_CRC_EN` defined: trailer `[15:0]` = CRC-16-CCITT over every byte of the header, length and data words, in transmit order.
  - Polynomial 0x1021, init 0xFFFF, MSB-first, no reflection, no final XOR.
  - Updated on each accepted byte; reset to 0xFFFF at `RdReq` acceptance.
- `HK_EGRESS_CRC_EN` undefined: trailer `[15:0]` = 16'h0000 and no CRC logic is built.

## Test plan
- `RdAddr`=0x000100, `RdLen`=1, `RegRdData`=0xDEADBEEF with 2-cycle latency, `TxRdyn`=0 → one `RegRdEn` at 0x000100. Bytes are 82 00 01 00, 01 00 00 00, EF BE AD DE, crcL crcH CD AB. With the CRC macro undefined, crcL and crcH are 00 00.
- `RdLen`=3 from 0x000100 → `RegRdAddr` = 0x100, 0x104, 0x108 in order, 24 bytes total, `Busy` low after the last byte.
- Same as scenario 1 with `TxRdyn` randomly high about 50% of cycles → identical byte stream, with `TxData` stable whenever a byte is stalled.
- `RdLen`=0 → 12 bytes (82 .. 00 00 00 00 .. trailer) and no `RegRdEn`.
- `RdReq` pulsed during DATA → `ErrOverlap` high for exactly 1 cycle, and the in-flight frame is byte-identical to the undisturbed case.
- `ARstn` low during DATA byte 2 → all outputs at reset values immediately. The next `RdReq` after release yields a complete, correct frame.

Source files
------------

// File: rtl/hk_byte_egress.sv
// Housekeeper egress serializer: fetches register words and streams a framed
// response (cmd, len, data, ABCD trailer) byte-wise, LSB first. CRC trailer via HK_EGRESS_CRC_EN.
module hk_byte_egress #(
    parameter int LEN_W = 16
) (
    input  logic             ClkEgress,
    input  logic             ARstn,
    input  logic             RdReq,
    input  logic [23:0]      RdAddr,
    input  logic [LEN_W-1:0] RdLen,
    output logic             Busy,
    output logic             ErrOverlap,
    output logic             RegRdEn,
    output logic [23:0]      RegRdAddr,
    input  logic [31:0]      RegRdData,
    input  logic             RegRdValid,
    output logic [7:0]       TxData,
    output logic             TxValid,
    input  logic             TxRdyn
);

    typedef enum logic [2:0] {
        S_IDLE, S_HDR, S_LEN, S_RDREQ, S_RDWAIT, S_DATA, S_TRL
    } state_t;

    state_t           state, state_d;
    logic [31:0]      shreg, shreg_d;
    logic [1:0]       byte_cnt, cnt_d;
    logic [LEN_W-1:0] remain, remain_d;
    logic [23:0]      addr, addr_d;
    logic             err_q;
    logic             tx_fire;
    logic             word_done;
    logic             req_accept;
    logic [15:0]      trl_lo;
    logic [31:0]      trailer;

    assign tx_fire    = TxValid && !TxRdyn;
    assign word_done  = tx_fire && (byte_cnt == 2'd3);
    assign req_accept = (state == S_IDLE) && RdReq;

`ifdef HK_EGRESS_CRC_EN
    logic [15:0] crc, crc_upd;

    function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c ^ {b, 8'h00};
        for (int i = 0; i < 8; i++)
            r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
        return r;
    endfunction

    assign crc_upd = crc16_byte(crc, shreg[7:0]);

    // Trailer bytes are excluded; the trailer carries the CRC itself.
    always_ff @(posedge ClkEgress or negedge ARstn) begin
        if (!ARstn)
            crc <= 16'h0000;
        else if (req_accept)
            crc <= 16'hFFFF;
        else if (tx_fire && state != S_TRL)
            crc <= crc_upd;
    end

    // Trailer is loaded on the last payload byte, so include that byte.
    assign trl_lo = crc_upd;
`else
    assign trl_lo = 16'h0000;
`endif

    assign trailer = {16'hABCD, trl_lo};

    always_comb begin
        state_d  = state;
        shreg_d  = shreg;
        cnt_d    = byte_cnt;
        remain_d = remain;
        addr_d   = addr;
        if (tx_fire) begin
            shreg_d = {8'h00, shreg[31:8]};
            cnt_d   = byte_cnt + 2'd1;
        end
        case (state)
            S_IDLE: begin
                if (RdReq) begin
                    state_d  = S_HDR;
                    shreg_d  = {RdAddr, 8'h82};
                    addr_d   = RdAddr;
                    remain_d = RdLen;
                    cnt_d    = 2'd0;
                end
            end
            S_HDR: begin
                if (word_done) begin
                    state_d = S_LEN;
                    shreg_d = 32'(remain);
                end
            end
            S_LEN: begin
                if (word_done) begin
                    if (remain != '0) begin
                        state_d = S_RDREQ;
                    end else begin
                        state_d = S_TRL;
                        shreg_d = trailer;
                    end
                end
            end
            S_RDREQ: state_d = S_RDWAIT;
            S_RDWAIT: begin
                if (RegRdValid) begin
                    state_d = S_DATA;
                    shreg_d = RegRdData;
                end
            end
            S_DATA: begin
                if (word_done) begin
                    remain_d = remain - LEN_W'(1);
                    addr_d   = addr + 24'd4;
                    if (remain != LEN_W'(1)) begin
                        state_d = S_RDREQ;
                    end else begin
                        state_d = S_TRL;
                        shreg_d = trailer;
                    end
                end
            end
            S_TRL: begin
                if (word_done)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge ClkEgress or negedge ARstn) begin
        if (!ARstn) begin
            state    <= S_IDLE;
            shreg    <= 32'h0;
            byte_cnt <= 2'd0;
            remain   <= '0;
            addr     <= 24'h0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_d;
            shreg    <= shreg_d;
            byte_cnt <= cnt_d;
            remain   <= remain_d;
            addr     <= addr_d;
            err_q    <= RdReq && (state != S_IDLE);
        end
    end

    assign Busy       = (state != S_IDLE);
    assign ErrOverlap = err_q;
    assign RegRdEn    = (state == S_RDREQ);
    assign RegRdAddr  = addr;
    assign TxData     = shreg[7:0];
    assign TxValid    = (state == S_HDR) || (state == S_LEN) ||
                        (state == S_DATA) || (state == S_TRL);

endmodule

// File: tb/tb_hk_byte_egress.sv
// Scoreboard bench for hk_byte_egress: expected bytes/addresses are queued at
// request time and consumed by independent monitors.
module tb_hk_byte_egress;

    logic        clk = 0;
    logic        rst_n = 1;
    logic        rd_req = 0;
    logic [23:0] rd_addr = 0;
    logic [15:0] rd_len = 0;
    logic        busy, err_overlap, reg_rd_en, tx_valid;
    logic [23:0] reg_rd_addr;
    logic [31:0] reg_rd_data = 0;
    logic        reg_rd_valid = 0;
    logic [7:0]  tx_data;
    logic        tx_rdyn = 0;

    hk_byte_egress #(.LEN_W(16)) dut (
        .ClkEgress(clk), .ARstn(rst_n), .RdReq(rd_req), .RdAddr(rd_addr), .RdLen(rd_len),
        .Busy(busy), .ErrOverlap(err_overlap), .RegRdEn(reg_rd_en), .RegRdAddr(reg_rd_addr),
        .RegRdData(reg_rd_data), .RegRdValid(reg_rd_valid),
        .TxData(tx_data), .TxValid(tx_valid), .TxRdyn(tx_rdyn)
    );

    always #5 clk = ~clk;

    logic [7:0]  exp_q[$];
    logic [23:0] addr_q[$];
    logic [15:0] exp_crc;
    int n_cmp = 0, n_err = 0, n_rx = 0, err_cycles = 0;
    bit stall_en = 0;
    bit prev_stall = 0;
    logic [7:0] prev_byte = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [23:0] a);
        return (a == 24'h000100) ? 32'hDEADBEEF : ({8'h5A, a} ^ 32'h00C3_3C00);
    endfunction

    function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c ^ {b, 8'h00};
        for (int i = 0; i < 8; i++)
            r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
        return r;
    endfunction

    task automatic push_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            logic [7:0] b;
            b = w[8*i +: 8];
            exp_q.push_back(b);
            exp_crc = crc_byte(exp_crc, b);
        end
    endtask

    task automatic expect_frame(input logic [23:0] a, input logic [15:0] len);
        logic [23:0] wa;
        exp_crc = 16'hFFFF;
        push_word({a, 8'h82});
        push_word({16'h0, len});
        wa = a;
        for (int i = 0; i < int'(len); i++) begin
            addr_q.push_back(wa);
            push_word(mem_word(wa));
            wa = wa + 24'd4;
        end
`ifdef HK_EGRESS_CRC_EN
        push_word({16'hABCD, exp_crc});
`else
        push_word({16'hABCD, 16'h0000});
`endif
    endtask

    // Caller is at posedge+2; request is sampled at the next edge.
    task automatic issue(input logic [23:0] a, input logic [15:0] len);
        expect_frame(a, len);
        rd_addr = a;
        rd_len  = len;
        rd_req  = 1;
        @(posedge clk); #2;
        rd_req = 0;
        check("first_busy", busy, 1);
        check("first_valid", tx_valid, 1);
        check("first_byte", tx_data, 8'h82);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk); #2;
            if (exp_q.size() == 0) break;
        end
        check("frame_drained", exp_q.size(), 0);
        check("busy_after_last", busy, 0);
        check("rd_addrs_consumed", addr_q.size(), 0);
    endtask

    task automatic wait_rx(input int target);
        for (int i = 0; i < 1000; i++) begin
            if (n_rx >= target) break;
            @(posedge clk); #2;
        end
        check("reach_byte", n_rx, target);
    endtask

    task automatic check_reset_outputs();
        check("rst_busy", busy, 0);
        check("rst_err", err_overlap, 0);
        check("rst_rden", reg_rd_en, 0);
        check("rst_rdaddr", reg_rd_addr, 0);
        check("rst_txdata", tx_data, 0);
        check("rst_txvalid", tx_valid, 0);
    endtask

    initial begin
        forever begin
            @(posedge clk); #1;
            tx_rdyn = stall_en ? ($urandom_range(0, 1) == 1) : 1'b0;
        end
    end

    // Byte monitor: a transfer happens at the posedge after this sample.
    always @(negedge clk) begin
        if (prev_stall)
            check("stall_hold", {23'h0, tx_valid, tx_data}, {23'h0, 1'b1, prev_byte});
        prev_stall = tx_valid && tx_rdyn;
        prev_byte  = tx_data;
        if (err_overlap) err_cycles++;
        if (tx_valid && !tx_rdyn) begin
            if (exp_q.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL tx_extra: got %h, expected no byte", tx_data);
            end else begin
                check("tx_byte", tx_data, exp_q.pop_front());
            end
            n_rx++;
        end
    end

    // Register bus responder with 2-cycle read latency.
    initial begin
        logic [23:0] a;
        forever begin
            @(negedge clk);
            if (reg_rd_en) begin
                a = reg_rd_addr;
                if (addr_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL rd_extra: got %h, expected no read", a);
                end else begin
                    check("rd_addr", a, addr_q.pop_front());
                end
                repeat (2) @(posedge clk);
                #1;
                reg_rd_valid = 1;
                reg_rd_data  = mem_word(a);
                @(posedge clk); #1;
                reg_rd_valid = 0;
            end
        end
    end

    initial begin
        int base;
        #3 rst_n = 0;
        repeat (3) @(posedge clk);
        #2;
        check_reset_outputs();
        rst_n = 1;
        @(posedge clk); #2;

        issue(24'h000100, 16'd1);
        wait_done();
        issue(24'h000100, 16'd3);
        wait_done();

        stall_en = 1;
        issue(24'h000100, 16'd1);
        wait_done();
        stall_en = 0;
        @(posedge clk); #2;

        issue(24'h000100, 16'd0);
        wait_done();

        issue(24'hFFFFF8, 16'd3);
        wait_done();

        // Overlapping request during the first data word.
        err_cycles = 0;
        base = n_rx;
        issue(24'h000200, 16'd2);
        wait_rx(base + 9);
        rd_addr = 24'h000555;
        rd_len  = 16'd7;
        rd_req  = 1;
        @(posedge clk); #2;
        rd_req = 0;
        wait_done();
        check("err_overlap_cycles", err_cycles, 1);

        // Reset while DATA byte 2 is being presented.
        base = n_rx;
        issue(24'h000300, 16'd2);
        wait_rx(base + 10);
        rst_n = 0;
        #1;
        check_reset_outputs();
        exp_q.delete();
        addr_q.delete();
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1;
        @(posedge clk); #2;
        check("post_rst_idle", busy, 0);
        issue(24'h000100, 16'd1);
        wait_done();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
